// File: rtl/mips_br_pkg.sv
// Branch operation encodings shared by the execute-stage branch logic.
package mips_br_pkg;

  localparam int unsigned BR_OP_W = 3;

  localparam logic [BR_OP_W-1:0] BR_NONE = 3'd0;
  localparam logic [BR_OP_W-1:0] BEQ     = 3'd1;
  localparam logic [BR_OP_W-1:0] BNE     = 3'd2;
  localparam logic [BR_OP_W-1:0] BLEZ    = 3'd3;
  localparam logic [BR_OP_W-1:0] BGTZ    = 3'd4;
  localparam logic [BR_OP_W-1:0] BLTZ    = 3'd5;
  localparam logic [BR_OP_W-1:0] BGEZ    = 3'd6;
  localparam logic [BR_OP_W-1:0] J       = 3'd7;

endpackage

// File: rtl/bpc_adder.sv
// Branch target adder: npc plus the word-scaled immediate. Carry-out is dropped so the
// target wraps modulo 2^XLEN.
module bpc_adder #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IMM_SHIFT = 2
) (
  input  logic [XLEN-1:0] npc_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] bpc_o
);

  assign bpc_o = npc_i + (imm_i << IMM_SHIFT);

endmodule

// File: rtl/ex_branch_unit.sv
// Execute-stage branch resolver: target, condition, mispredict check, EX/MEM register and
// saturating branch/mispredict statistics.
module ex_branch_unit
  import mips_br_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IMM_SHIFT = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EX_valid,
  input  logic               EX_stall,
  input  logic               EX_flush,
  input  logic [BR_OP_W-1:0] EX_br_op,
  input  logic [XLEN-1:0]    EX_npc,
  input  logic [XLEN-1:0]    EX_imm,
  input  logic [XLEN-1:0]    EX_rs_data,
  input  logic [XLEN-1:0]    EX_rt_data,
  input  logic               EX_pred_taken,
  output logic               MEM_valid,
  output logic [XLEN-1:0]    MEM_bpc,
  output logic               MEM_taken,
  output logic               MEM_redirect,
  output logic [XLEN-1:0]    MEM_redirect_pc,
  output logic [CNT_W-1:0]   br_count,
  output logic [CNT_W-1:0]   mispred_count
);

  logic [XLEN-1:0]  bpc;
  logic             taken, is_br, mispred, accept;
  logic             rs_neg, rs_zero;
  logic             valid_q, taken_q, redirect_q;
  logic [XLEN-1:0]  bpc_q, rpc_q;
  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

  bpc_adder #(
    .XLEN      (XLEN),
    .IMM_SHIFT (IMM_SHIFT)
  ) u_bpc_adder (
    .npc_i (EX_npc),
    .imm_i (EX_imm),
    .bpc_o (bpc)
  );

  assign rs_neg  = EX_rs_data[XLEN-1];
  assign rs_zero = (EX_rs_data == '0);

  always_comb begin
    taken = 1'b0;
    case (EX_br_op)
      BEQ:     taken = (EX_rs_data == EX_rt_data);
      BNE:     taken = (EX_rs_data != EX_rt_data);
      BLEZ:    taken = rs_neg | rs_zero;
      BGTZ:    taken = ~rs_neg & ~rs_zero;
      BLTZ:    taken = rs_neg;
      BGEZ:    taken = ~rs_neg;
      J:       taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign is_br   = (EX_br_op != BR_NONE);
  assign mispred = is_br & (taken != EX_pred_taken);
  assign accept  = EX_valid & ~EX_stall & ~EX_flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
      bpc_q      <= '0;
      rpc_q      <= '0;
      br_cnt_q   <= '0;
      mis_cnt_q  <= '0;
    end else begin
      if (accept) begin
        valid_q    <= 1'b1;
        taken_q    <= taken;
        redirect_q <= mispred;
        bpc_q      <= bpc;
        rpc_q      <= taken ? bpc : EX_npc;
        if (is_br && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 1'b1;
        if (mispred && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 1'b1;
      end else if (EX_flush || !EX_stall) begin
        valid_q    <= 1'b0;
        redirect_q <= 1'b0;
      end else begin
        // Held by stall: keep payload, but a redirect must fire only once.
        redirect_q <= 1'b0;
      end
    end
  end

  assign MEM_valid       = valid_q;
  assign MEM_bpc         = bpc_q;
  assign MEM_taken       = taken_q;
  assign MEM_redirect    = redirect_q;
  assign MEM_redirect_pc = rpc_q;
  assign br_count        = br_cnt_q;
  assign mispred_count   = mis_cnt_q;

endmodule
